// File: rtl/mix_columns_seq.sv
// rtl/mix_columns_seq.sv - AES MixColumns sequencer, one column per cycle on a shared mixer

// One AES MixColumns column in GF(2^8), polynomial 0x11B; byte a0 is the column MSB.
module mix_single_column (
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] a0, a1, a2, a3;

  // Standard 2-3-1-1 circulant matrix, 3*x expressed as xtime(x)^x
  always_comb begin
    a0 = col_in[31:24];
    a1 = col_in[23:16];
    a2 = col_in[15:8];
    a3 = col_in[7:0];
    col_out[31:24] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    col_out[23:16] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    col_out[15:8]  = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    col_out[7:0]   = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

endmodule

// Accepts a 128-bit state, mixes columns 0..3 over four cycles, holds the result until taken.
module mix_columns_seq #(
  parameter bit FAST_ACCEPT = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t       state;
  state_t       state_next;
  logic [1:0]   col;
  logic [127:0] work;
  logic         bypass;
  logic [31:0]  work_col;
  logic [31:0]  mixed_col;
  logic [31:0]  write_col;
  logic         accept;

  mix_single_column u_mix (
    .col_in  (work_col),
    .col_out (mixed_col)
  );

  assign accept = in_valid & in_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode; col==3 is the last column write in BUSY
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = BUSY;
      BUSY:    if (col == 2'd3) state_next = DONE;
      DONE:    if (out_ready) state_next = accept ? BUSY : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from state; only the fast path looks at out_ready
  always_comb begin
    in_ready  = (state == IDLE) || (FAST_ACCEPT && (state == DONE) && out_ready);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // Select the work column currently being processed
  always_comb begin
    case (col)
      2'd0:    work_col = work[127:96];
      2'd1:    work_col = work[95:64];
      2'd2:    work_col = work[63:32];
      default: work_col = work[31:0];
    endcase
    write_col = bypass ? work_col : mixed_col;
  end

  // Capture on accept, then write one output column per BUSY cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      work      <= '0;
      bypass    <= 1'b0;
      col       <= 2'd0;
      out_state <= '0;
    end else if (accept) begin
      work   <= in_state;
      bypass <= in_bypass;
      col    <= 2'd0;
    end else if (state == BUSY) begin
      case (col)
        2'd0:    out_state[127:96] <= write_col;
        2'd1:    out_state[95:64]  <= write_col;
        2'd2:    out_state[63:32]  <= write_col;
        default: out_state[31:0]   <= write_col;
      endcase
      col <= col + 2'd1;
    end
  end

endmodule

// File: tb/tb_mix_columns_seq.sv
// tb/tb_mix_columns_seq.sv - self-checking bench for mix_columns_seq
module tb_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_bypass, out_ready;
  logic [127:0] in_state;
  logic         in_ready, out_valid, busy;
  logic [127:0] out_state;
  logic         in_valid1, in_bypass1, out_ready1;
  logic [127:0] in_state1;
  logic         in_ready1, out_valid1, busy1;
  logic [127:0] out_state1;

  int total = 0;
  int bad   = 0;
  logic [127:0] q0[$];
  logic [127:0] q1[$];

  localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] KC_IN    = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
  localparam logic [127:0] KC_OUT   = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;

  always #5 clk = ~clk;

  mix_columns_seq #(.FAST_ACCEPT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_state(in_state), .in_bypass(in_bypass), .out_valid(out_valid),
    .out_ready(out_ready), .out_state(out_state), .busy(busy)
  );

  mix_columns_seq #(.FAST_ACCEPT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_state(in_state1), .in_bypass(in_bypass1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_state(out_state1), .busy(busy1)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] mix_model(input logic [127:0] s);
    logic [127:0] r = '0;
    logic [7:0] a [4];
    logic [7:0] m [4][4];
    m[0] = '{8'h02, 8'h03, 8'h01, 8'h01};
    m[1] = '{8'h01, 8'h02, 8'h03, 8'h01};
    m[2] = '{8'h01, 8'h01, 8'h02, 8'h03};
    m[3] = '{8'h03, 8'h01, 8'h01, 8'h02};
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) a[k] = s[127 - 32*c - 8*k -: 8];
      for (int row = 0; row < 4; row++) begin
        logic [7:0] acc = 8'h00;
        for (int k = 0; k < 4; k++) acc = acc ^ gmul(m[row][k], a[k]);
        r[127 - 32*c - 8*row -: 8] = acc;
      end
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one block to dut0, wait for out_valid; leaves the bench in DONE
  task automatic run0(input logic [127:0] s, input logic byp, input string tag);
    int lat;
    logic [127:0] e;
    in_valid  = 1'b1;
    in_state  = s;
    in_bypass = byp;
    check($sformatf("%s in_ready", tag), 128'(in_ready), 128'(1));
    q0.push_back(byp ? s : mix_model(s));
    step();
    in_valid  = 1'b0;
    in_state  = ~s;
    in_bypass = ~byp;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check($sformatf("%s latency", tag), 128'(lat), 128'(4));
    e = (q0.size() > 0) ? q0.pop_front() : 'x;
    check($sformatf("%s data", tag), out_state, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] held, ra, rb;
    rst_n = 1'b0; in_valid = 1'b0; in_state = '0; in_bypass = 1'b0; out_ready = 1'b1;
    in_valid1 = 1'b0; in_state1 = '0; in_bypass1 = 1'b0; out_ready1 = 1'b1;
    step();
    step();
    check("reset out_valid", 128'(out_valid), 128'(0));
    check("reset busy", 128'(busy), 128'(0));
    check("reset out_state", out_state, '0);
    rst_n = 1'b1;
    check("reset in_ready", 128'(in_ready), 128'(1));

    run0(FIPS_IN, 1'b0, "fips");
    check("fips const", out_state, FIPS_OUT);
    step();
    check("fips idle busy", 128'(busy), 128'(0));

    run0(KC_IN, 1'b0, "known_cols");
    check("known_cols const", out_state, KC_OUT);
    step();

    run0(FIPS_IN, 1'b1, "bypass");
    check("bypass const", out_state, FIPS_IN);
    step();

    for (int i = 0; i < 3; i++) begin
      ra = {$urandom, $urandom, $urandom, $urandom};
      run0(ra, 1'b0, $sformatf("rand%0d", i));
      step();
    end

    // Backpressure: DONE held for 10 cycles while in_valid pulses
    out_ready = 1'b0;
    run0(KC_IN, 1'b0, "bp");
    held = out_state;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_state = {4{$urandom}};
      step();
      check($sformatf("bp stable%0d", i), out_state, held);
      check($sformatf("bp in_ready%0d", i), 128'(in_ready), 128'(0));
      check($sformatf("bp out_valid%0d", i), 128'(out_valid), 128'(1));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    check("bp released busy", 128'(busy), 128'(0));
    check("bp released out_valid", 128'(out_valid), 128'(0));
    check("bp released in_ready", 128'(in_ready), 128'(1));

    // Reset after E2
    in_valid = 1'b1; in_state = FIPS_IN; in_bypass = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    step();
    check("midrst busy before", 128'(busy), 128'(1));
    rst_n = 1'b0;
    step();
    check("midrst out_valid", 128'(out_valid), 128'(0));
    check("midrst busy", 128'(busy), 128'(0));
    check("midrst out_state", out_state, '0);
    rst_n = 1'b1;
    q0.delete();
    run0(KC_IN, 1'b0, "after_rst");
    check("after_rst const", out_state, KC_OUT);
    step();

    // Back-to-back on the FAST_ACCEPT instance
    ra = FIPS_IN;
    rb = {$urandom, $urandom, $urandom, $urandom};
    in_valid1 = 1'b1; in_state1 = ra;
    q1.push_back(mix_model(ra));
    step();
    in_state1 = rb;
    q1.push_back(mix_model(rb));
    step(); step(); step();
    check("b2b first early", 128'(out_valid1), 128'(0));
    step();
    check("b2b first valid", 128'(out_valid1), 128'(1));
    check("b2b first data", out_state1, q1.pop_front());
    check("b2b in_ready in done", 128'(in_ready1), 128'(1));
    step();
    in_valid1 = 1'b0;
    check("b2b second accepted", 128'(busy1), 128'(1));
    check("b2b gap out_valid", 128'(out_valid1), 128'(0));
    step(); step(); step();
    check("b2b second early", 128'(out_valid1), 128'(0));
    step();
    check("b2b second valid", 128'(out_valid1), 128'(1));
    check("b2b second data", out_state1, q1.pop_front());
    step();
    check("b2b idle", 128'(busy1), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
